// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision constants, rounding-mode codes and FP sequencer states
package fp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;

    localparam logic [31:0] QNAN = 32'h7fc0_0000;
    localparam logic [31:0] PINF = 32'h7f80_0000;
    localparam logic [31:0] PMAX = 32'h7f7f_ffff;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RUP = 2'b10,
        RM_RDN = 2'b11
    } round_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_MUL    = 3'd2,
        ST_NORM   = 3'd3,
        ST_ROUND  = 3'd4
    } fp_state_e;

endpackage

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - rounds a normalized positive significand and packs it into binary32
module fp_round_pack
    import fp_pkg::*;
(
    input  logic [23:0]       sig,
    input  logic              guard,
    input  logic              round_bit,
    input  logic              sticky,
    input  logic signed [9:0] exp_in,
    input  logic [1:0]        rm,
    output logic [31:0]       value,
    output logic              overflow,
    output logic              underflow,
    output logic              inexact
);

    logic              inc;
    logic [24:0]       sum;
    logic [22:0]       man;
    logic signed [9:0] exp_r;

    // Sign is always positive, so round-down behaves like truncation and round-up like ceiling.
    always_comb begin
        inc = 1'b0;
        case (rm)
            RM_RNE:  inc = guard & (round_bit | sticky | sig[0]);
            RM_RUP:  inc = guard | round_bit | sticky;
            default: inc = 1'b0;
        endcase

        sum = {1'b0, sig} + {24'd0, inc};
        if (sum[24]) begin
            man   = sum[23:1];
            exp_r = exp_in + 10'sd1;
        end else begin
            man   = sum[22:0];
            exp_r = exp_in;
        end

        overflow  = (exp_r >= 10'sd255);
        underflow = (exp_r <= 10'sd0);

        if (overflow) begin
            value = (rm == RM_RNE || rm == RM_RUP) ? PINF : PMAX;
        end else if (underflow) begin
            value = 32'd0;
        end else begin
            value = {1'b0, exp_r[7:0], man};
        end

        inexact = guard | round_bit | sticky | overflow | underflow;
    end

endmodule

// File: rtl/fp_square_seq.sv
// rtl/fp_square_seq.sv - multicycle binary32 squarer with shift-add mantissa engine; FP_SQUARE_FLAGS_EN adds the flags port
module fp_square_seq
    import fp_pkg::*;
#(
    parameter int D_LEN          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [D_LEN-1:0] A,
    input  logic [1:0]       round_mode,
    output logic [D_LEN-1:0] result,
    output logic             done,
    output logic             busy
`ifdef FP_SQUARE_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    localparam int         N        = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] CNT_LAST = 5'(N - 1);

    if (D_LEN != 32) begin : g_bad_dlen
        $error("fp_square_seq: only D_LEN = 32 is supported");
    end
    if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 &&
        BITS_PER_CYCLE != 4 && BITS_PER_CYCLE != 8) begin : g_bad_bpc
        $error("fp_square_seq: BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    fp_state_e         state_q, state_d;

    // Captured operand (sign is irrelevant for a square) and rounding mode
    logic [30:0]       a_q;
    logic [1:0]        rm_q;

    // Shift-add engine
    logic [47:0]       acc_q;
    logic [47:0]       mcand_q;
    logic [23:0]       mplr_q;
    logic [4:0]        cnt_q;
    logic [47:0]       pp;

    // Normalized significand, rounding bits and exponent
    logic signed [9:0] exp_q;
    logic [23:0]       sig_q;
    logic              g_q, r_q, s_q;

    // Special-case bypass
    logic              spec_q;
    logic [31:0]       spec_val_q;
    logic              spec_inv_q;

    // ROUND is split in two: first cycle registers the rounded word, second commits it
    logic              rnd_phase_q;
    logic [31:0]       res_q;
    logic [3:0]        flg_q;

    logic              exp_all1, exp_zero, man_zero;
    logic              is_nan, is_special;
    logic [31:0]       spec_val;

    logic [31:0]       rp_value;
    logic              rp_ovf, rp_unf, rp_inx;

    // Operand classification; denormals are treated as zero
    always_comb begin
        exp_all1   = &a_q[30:23];
        exp_zero   = ~|a_q[30:23];
        man_zero   = ~|a_q[22:0];
        is_nan     = exp_all1 & ~man_zero;
        is_special = exp_all1 | exp_zero;
        if (is_nan) begin
            spec_val = QNAN;
        end else if (exp_all1) begin
            spec_val = PINF;
        end else begin
            spec_val = 32'd0;
        end
    end

    // Partial product for the multiplier bits consumed this cycle
    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplr_q[i]) begin
                pp = pp + (mcand_q << i);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_UNPACK;
            ST_UNPACK: state_d = is_special ? ST_ROUND : ST_MUL;
            ST_MUL:    if (cnt_q == CNT_LAST) state_d = ST_NORM;
            ST_NORM:   state_d = ST_ROUND;
            ST_ROUND:  if (rnd_phase_q) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    fp_round_pack u_round_pack (
        .sig       (sig_q),
        .guard     (g_q),
        .round_bit (r_q),
        .sticky    (s_q),
        .exp_in    (exp_q),
        .rm        (rm_q),
        .value     (rp_value),
        .overflow  (rp_ovf),
        .underflow (rp_unf),
        .inexact   (rp_inx)
    );

    // Datapath and handshake registers, advanced according to the current state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            rm_q        <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            sig_q       <= '0;
            g_q         <= 1'b0;
            r_q         <= 1'b0;
            s_q         <= 1'b0;
            spec_q      <= 1'b0;
            spec_val_q  <= '0;
            spec_inv_q  <= 1'b0;
            rnd_phase_q <= 1'b0;
            res_q       <= '0;
            flg_q       <= '0;
            result      <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
`ifdef FP_SQUARE_FLAGS_EN
            flags       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= A[30:0];
                        rm_q  <= round_mode;
                        busy  <= 1'b1;
                        done  <= 1'b0;
`ifdef FP_SQUARE_FLAGS_EN
                        flags <= '0;
`endif
                    end
                end
                ST_UNPACK: begin
                    spec_q     <= is_special;
                    spec_val_q <= spec_val;
                    spec_inv_q <= is_nan;
                    mcand_q    <= {24'd0, 1'b1, a_q[22:0]};
                    mplr_q     <= {1'b1, a_q[22:0]};
                    acc_q      <= '0;
                    cnt_q      <= '0;
                    exp_q      <= $signed({1'b0, a_q[30:23], 1'b0}) - 10'(EXP_BIAS);
                end
                ST_MUL: begin
                    acc_q   <= acc_q + pp;
                    mcand_q <= mcand_q << BITS_PER_CYCLE;
                    mplr_q  <= mplr_q >> BITS_PER_CYCLE;
                    cnt_q   <= cnt_q + 5'd1;
                end
                ST_NORM: begin
                    if (acc_q[47]) begin
                        sig_q <= acc_q[47:24];
                        g_q   <= acc_q[23];
                        r_q   <= acc_q[22];
                        s_q   <= |acc_q[21:0];
                        exp_q <= exp_q + 10'sd1;
                    end else begin
                        sig_q <= acc_q[46:23];
                        g_q   <= acc_q[22];
                        r_q   <= acc_q[21];
                        s_q   <= |acc_q[20:0];
                    end
                end
                ST_ROUND: begin
                    if (!rnd_phase_q) begin
                        rnd_phase_q <= 1'b1;
                        res_q       <= spec_q ? spec_val_q : rp_value;
                        flg_q       <= spec_q ? {spec_inv_q, 3'b000}
                                              : {1'b0, rp_ovf, rp_unf, rp_inx};
                    end else begin
                        rnd_phase_q <= 1'b0;
                        result      <= res_q;
                        done        <= 1'b1;
                        busy        <= 1'b0;
`ifdef FP_SQUARE_FLAGS_EN
                        flags       <= flg_q;
`endif
                    end
                end
                default: begin
                    rnd_phase_q <= 1'b0;
                end
            endcase
        end
    end

`ifndef FP_SQUARE_FLAGS_EN
    logic unused_flag_bits;
    assign unused_flag_bits = &{1'b0, flg_q};
`endif
    logic unused_sign;
    assign unused_sign = &{1'b0, A[31]};

endmodule
